// File: rtl/regfile_mp.sv
// Multi-read-port register file with a per-register pending-write scoreboard
// and a one-register-per-cycle clear engine. Optional forwarding: REGFILE_BYPASS_EN.
module regfile_mp #(
    parameter int XLEN     = 32,
    parameter int NREG     = 32,
    parameter int NRD      = 2,
    parameter int ZERO_REG = 1,
    localparam int AW      = $clog2(NREG)
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic [NRD*AW-1:0]     i_ra,
    output logic [NRD*XLEN-1:0]   o_rd,
    output logic [NRD-1:0]        o_rdy,
    input  logic [AW-1:0]         i_aw,
    input  logic                  i_ew,
    input  logic [XLEN-1:0]       i_dw,
    input  logic                  i_rsv,
    input  logic [AW-1:0]         i_rsv_a,
    input  logic                  i_clr,
    output logic                  o_busy
);

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } state_t;

    state_t              r_state;
    logic [AW-1:0]       r_cnt;
    logic                r_busy;
    logic [NREG-1:0]     r_pend;
    logic [NREG-1:0]     w_pend_next;
    logic [XLEN-1:0]     r_mem [NREG];
    logic                w_wr_ok;

    assign w_wr_ok = i_ew && !((ZERO_REG != 0) && (i_aw == '0));
    assign o_busy  = r_busy;

    // Reserve takes priority over the writeback clear of the same register.
    genvar gi;
    generate
        for (gi = 0; gi < NREG; gi++) begin : g_pend
            if ((ZERO_REG != 0) && (gi == 0)) begin : g_zero
                assign w_pend_next[gi] = 1'b0;
            end else begin : g_norm
                assign w_pend_next[gi] = (i_rsv && (i_rsv_a == AW'(gi))) ? 1'b1 :
                                         (i_ew  && (i_aw    == AW'(gi))) ? 1'b0 :
                                         r_pend[gi];
            end
        end
    endgenerate

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_busy  <= 1'b0;
            r_pend  <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (i_clr) begin
                        r_state <= ST_CLEAR;
                        r_cnt   <= '0;
                        r_busy  <= 1'b1;
                        r_pend  <= '0;
                    end else begin
                        r_pend  <= w_pend_next;
                    end
                end
                ST_CLEAR: begin
                    if (r_cnt == AW'(NREG - 1)) begin
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
                        r_cnt   <= '0;
                    end else begin
                        r_cnt   <= r_cnt + 1'b1;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    // Storage is deliberately not reset; only the clear engine or writes define it.
    always_ff @(posedge i_clk) begin
        if (r_state == ST_CLEAR) begin
            r_mem[r_cnt] <= '0;
        end else if (w_wr_ok) begin
            r_mem[i_aw] <= i_dw;
        end
    end

    generate
        for (gi = 0; gi < NRD; gi++) begin : g_rd
            logic [AW-1:0]   w_ra;
            logic [XLEN-1:0] w_data;
            logic            w_rdy;

            assign w_ra = i_ra[gi*AW +: AW];

            always_comb begin
                w_data = r_mem[w_ra];
                w_rdy  = ~r_pend[w_ra];
                if ((ZERO_REG != 0) && (w_ra == '0)) begin
                    w_data = '0;
                    w_rdy  = 1'b1;
                end
`ifdef REGFILE_BYPASS_EN
                if (i_ew && (r_state == ST_IDLE) && (i_aw == w_ra) &&
                    ((i_aw != '0) || (ZERO_REG == 0))) begin
                    w_data = i_dw;
                    w_rdy  = 1'b1;
                end
`endif
            end

            assign o_rd[gi*XLEN +: XLEN] = w_data;
            assign o_rdy[gi]             = w_rdy;
        end
    endgenerate

endmodule

// File: tb/tb_regfile_mp.sv
// Scoreboard bench for regfile_mp: stimulus pushes expectations from a
// behavioural model, a negedge monitor pops and compares them.
module tb_regfile_mp;

    localparam int XLEN = 32;
    localparam int NREG = 32;
    localparam int NRD  = 2;
    localparam int AW   = 5;

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic [NRD*AW-1:0]    ra_bus;
    logic [NRD*XLEN-1:0]  o_rd;
    logic [NRD-1:0]       o_rdy;
    logic [AW-1:0]        aw;
    logic                 ew;
    logic [XLEN-1:0]      dw;
    logic                 rsv;
    logic [AW-1:0]        rsv_a;
    logic                 clr;
    logic                 o_busy;

    always #5 clk = ~clk;

    regfile_mp #(.XLEN(XLEN), .NREG(NREG), .NRD(NRD), .ZERO_REG(1)) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .i_ra    (ra_bus),
        .o_rd    (o_rd),
        .o_rdy   (o_rdy),
        .i_aw    (aw),
        .i_ew    (ew),
        .i_dw    (dw),
        .i_rsv   (rsv),
        .i_rsv_a (rsv_a),
        .i_clr   (clr),
        .o_busy  (o_busy)
    );

    typedef struct {
        string       name;
        int          kind;   // 0 read data, 1 ready, 2 busy
        int          port;
        logic [31:0] exp;
    } exp_t;

    exp_t q[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    // Reference model: what each register holds, whether it is known, pending flags.
    logic [31:0] m_mem   [NREG];
    bit          m_known [NREG];
    bit          m_pend  [NREG];
    bit          m_busy;
    int          m_clr_left;
    int          m_clr_idx;

    exp_t        mx;
    logic [31:0] mact;

    always @(negedge clk) begin
        while (q.size() > 0) begin
            mx = q.pop_front();
            case (mx.kind)
                0:       mact = o_rd[mx.port*XLEN +: XLEN];
                1:       mact = {31'b0, o_rdy[mx.port]};
                default: mact = {31'b0, o_busy};
            endcase
            n_tests++;
            if (mact !== mx.exp) begin
                n_fail++;
                $display("FAIL %s: got %h expected %h", mx.name, mact, mx.exp);
            end
        end
    end

    function automatic void push(string nm, int kind, int port, logic [31:0] e);
        exp_t x;
        x.name = nm;
        x.kind = kind;
        x.port = port;
        x.exp  = e;
        q.push_back(x);
    endfunction

    function automatic void model_reset();
        for (int r = 0; r < NREG; r++) m_pend[r] = 0;
        m_busy     = 0;
        m_clr_left = 0;
        m_clr_idx  = 0;
    endfunction

    function automatic void model_update();
        if (!rst_n) begin
            model_reset();
        end else if (m_busy) begin
            m_mem[m_clr_idx]   = 32'h0;
            m_known[m_clr_idx] = 1;
            m_clr_idx++;
            m_clr_left--;
            if (m_clr_left == 0) m_busy = 0;
        end else begin
            if (ew && aw != 0) begin
                m_mem[aw]   = dw;
                m_known[aw] = 1;
                m_pend[aw]  = 0;
            end
            if (rsv && rsv_a != 0) m_pend[rsv_a] = 1;
            if (clr) begin
                for (int r = 0; r < NREG; r++) m_pend[r] = 0;
                m_busy     = 1;
                m_clr_left = NREG;
                m_clr_idx  = 0;
            end
        end
    endfunction

    task automatic set_ra(int p, int a);
        ra_bus[p*AW +: AW] = AW'(a);
    endtask

    task automatic step(string nm);
        int          a;
        logic [31:0] e;
        bit          erdy;
        bit          chk;
        $display("[TB] %s ew=%0d aw=%0d dw=%h rsv=%0d rsv_a=%0d clr=%0d ra=%h",
                 nm, ew, aw, dw, rsv, rsv_a, clr, ra_bus);
        for (int p = 0; p < NRD; p++) begin
            a    = int'(ra_bus[p*AW +: AW]);
            chk  = 1;
            if (a == 0) begin
                e    = 32'h0;
                erdy = 1;
            end else begin
                e    = m_mem[a];
                erdy = !m_pend[a];
                chk  = m_known[a];
            end
`ifdef REGFILE_BYPASS_EN
            if (ew && !m_busy && int'(aw) == a && a != 0) begin
                e    = dw;
                erdy = 1;
                chk  = 1;
            end
`endif
            if (chk) push($sformatf("%s rd%0d(r%0d)", nm, p, a), 0, p, e);
            push($sformatf("%s rdy%0d(r%0d)", nm, p, a), 1, p, {31'b0, erdy});
        end
        push($sformatf("%s busy", nm), 2, 0, {31'b0, m_busy});
        @(negedge clk);
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic idle_inputs();
        ew = 0; rsv = 0; clr = 0;
    endtask

    initial begin
        for (int r = 0; r < NREG; r++) begin
            m_mem[r]   = 32'h0;
            m_known[r] = 0;
            m_pend[r]  = 0;
        end
        model_reset();
        rst_n = 0; ra_bus = '0; aw = '0; dw = '0; rsv_a = '0;
        idle_inputs();
        set_ra(0, 5); set_ra(1, 6);
        #1;
        step("reset");
        rst_n = 1;

        // Test 1: full clear
        clr = 1;
        step("t1 clr");
        clr = 0;
        for (int i = 0; i < NREG; i++) step($sformatf("t1 busy%0d", i));
        set_ra(0, 5);
        step("t1 read r5");

        // Test 2: write and zero-register write
        ew = 1; aw = 3; dw = 32'hDEADBEEF;
        step("t2 wr r3");
        ew = 0; set_ra(1, 3);
        step("t2 rd r3");
        ew = 1; aw = 0; dw = 32'h1234;
        step("t2 wr r0");
        ew = 0; set_ra(0, 0);
        step("t2 rd r0");

        // Test 3: reserve then writeback
        rsv = 1; rsv_a = 7;
        step("t3 rsv r7");
        rsv = 0; set_ra(0, 7);
        step("t3 pend r7");
        ew = 1; aw = 7; dw = 32'h55;
        step("t3 wr r7");
        ew = 0;
        step("t3 rd r7");

        // Test 4: reserve and write same register same cycle
        rsv = 1; rsv_a = 9; ew = 1; aw = 9; dw = 32'hA5;
        set_ra(1, 9);
        step("t4 rsv+wr r9");
        idle_inputs(); set_ra(0, 9);
        step("t4 rd r9");

        // Test 5: reset aborts clear in its 10th busy cycle
        clr = 1;
        step("t5 clr");
        clr = 0;
        for (int i = 0; i < 9; i++) step($sformatf("t5 busy%0d", i));
        rst_n = 0;
        model_reset();
        #1;
        step("t5 async reset");
        rst_n = 1;
        for (int r = 0; r < 10; r += 2) begin
            set_ra(0, r); set_ra(1, r + 1);
            step($sformatf("t5 rd r%0d", r));
        end

        // Test 6: same-cycle write/read of register 4
        ew = 1; aw = 4; dw = 32'h11;
        step("t6 wr r4");
        ew = 1; aw = 4; dw = 32'h99; set_ra(0, 4);
        step("t6 wr+rd r4");
        ew = 0;
        step("t6 rd r4");

        // Randomized traffic
        for (int i = 0; i < 300; i++) begin
            set_ra(0, int'($urandom_range(NREG - 1)));
            set_ra(1, int'($urandom_range(NREG - 1)));
            ew    = ($urandom_range(1) == 1);
            aw    = AW'($urandom_range(NREG - 1));
            dw    = $urandom;
            rsv   = ($urandom_range(9) < 3);
            rsv_a = ($urandom_range(3) == 0) ? aw : AW'($urandom_range(NREG - 1));
            clr   = ($urandom_range(49) == 0);
            step($sformatf("rnd%0d", i));
        end
        idle_inputs();
        @(negedge clk);
        #1;
        if (q.size() != 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL drain: got %0d pending expectations required 0", q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
